man_tx_ctrl: RTL and testbench
==============================

Name: man_tx_ctrl

Overview:
Frame sequencer for the Manchester encoder on the PICC→PCD RFID transmit path (106 kb/s, clk = fc/16 = 847.5 kHz, 8 clocks per ETU).
- Accepts bytes over a valid/ready handshake.
- Emits SOF, data bits LSB-first, an odd parity bit per byte, then EOF, one bit per ETU.
- Drives the encoder's data and enable inputs so the encoder's ETU phase starts aligned to the SOF.

Parameters:
ETU_CLKS, 8, clocks per ETU (≥2)
CNT_W, 3, width of the ETU clock counter (2^CNT_W ≥ ETU_CLKS)
EOF_ETUS, 1, ETUs with encoder disabled after the last bit, before done

Ports:
clk  input  1  transmit clock, fc/16; all logic on posedge
in_rst_n  input  1  synchronous active-low reset
in_valid  input  1  byte offered on in_byte
in_byte  input  8  frame byte
in_last  input  1  qualifies in_byte as the final byte of the frame
out_ready  output  1  holding register empty; transfer on in_valid & out_ready
out_mod_data  output  1  bit to encoder data input
out_mod_enable  output  1  to encoder enable input; high only during SOF/data/parity
out_busy  output  1  frame in progress (SOF through EOF)
out_done  output  1  one-cycle pulse at end of EOF
out_underrun  output  1  one-cycle pulse when a byte is missing at a byte boundary

Behaviour:
- Reset (in_rst_n=0 at posedge): FSM=IDLE, holding register empty, counters 0. Outputs: out_ready=1, out_mod_data=0, out_mod_enable=0, out_busy=0, out_done=0, out_underrun=0. Reset mid-frame aborts immediately; no done or underrun pulse.
- Holding register: 8 data bits + last flag. out_ready = ~full.
  - Load on in_valid & out_ready; the register becomes full at the next edge.
  - Cleared when the FSM moves it into the shift register.
  - Load and unload in the same cycle are legal and leave the register full with the new byte.
- States: IDLE, SOF, DATA, PAR, EOF.
- ETU timing: etu_cnt runs 0..ETU_CLKS-1 in SOF/DATA/PAR/EOF. etu_end = (etu_cnt == ETU_CLKS-1). State and bit changes occur only on etu_end.
- IDLE: when the holding register is full → SOF next edge.
  - Byte moves to shift register; etu_cnt=0; out_busy=1; out_mod_enable=1; out_mod_data=1.
  - Latency: a handshake at edge T gives SOF visible from edge T+2.
- SOF: 1 ETU of data=1, then → DATA with bit_idx=0 and out_mod_data = shift[0].
- DATA: each etu_end shifts right, bit_idx+1. After bit 7, → PAR; out_mod_data = ~^byte (odd parity, so total ones incl. parity is odd).
- PAR: at etu_end:
  - byte last=1 → EOF.
  - Else holding full → load it, → DATA with bit_idx=0, no gap ETU.
  - Else (underrun) → EOF with out_underrun pulsed that cycle.
- EOF: out_mod_enable=0, out_mod_data=0, out_busy=1 for EOF_ETUS×ETU_CLKS clocks. Then → IDLE, out_busy=0, out_done=1 for one cycle.
  - A byte already waiting in the holding register starts a new SOF on the following edge (minimum 1 IDLE cycle).
- out_mod_data/out_mod_enable are registered, glitch-free, and constant within an ETU.
- During a frame, bytes for the next frame may be loaded. in_last is latched per byte.

Optional Feature:
MAN_TX_PARITY_EN
- Defined: PAR state present as above; 10 ETUs for 1 byte incl. SOF.
- Undefined: PAR is skipped. After bit 7 the byte-boundary decision (next byte / EOF / underrun) is taken directly at that etu_end. 9 ETUs per 1-byte frame incl. SOF.

Test Plan:
1. Reset, then send 0xA5 with last=1 (parity on) → enable high for 80 clocks. Bits per ETU: 1 (SOF), 1,0,1,0,0,1,0,1, parity 1. Then 8 clocks of enable=0, done pulse, busy falls with done.
2. Back-to-back 0x01 (last=0), 0x00 (last=1), valid held high → no gap between bytes. Parity bits 0 then 1. Enable high for 19 ETUs = 152 clocks. out_ready low while the holding register is full.
3. Send 0x3C last=0, then withhold valid → underrun pulse at the parity etu_end, EOF follows, done pulses, no further data ETUs.
4. Assert in_rst_n=0 during DATA bit 3 → next edge all outputs at reset values, out_ready=1, no done. A new 0xFF frame afterwards is correct.
5. Build without MAN_TX_PARITY_EN, send 0x80 last=1 → bits 1,0,0,0,0,0,0,0,1, enable high for 72 clocks, then EOF/done.
6. Assert valid with the next frame's byte during EOF → accepted; SOF begins exactly 1 cycle after the done pulse.

Source files
------------

// File: rtl/man_tx_ctrl_if.sv
// man_tx_ctrl_if: byte-feed handshake between a frame source and man_tx_ctrl.
//   in_valid   source -> sequencer  byte offered on in_byte
//   in_byte    source -> sequencer  frame byte (transmitted LSB first)
//   in_last    source -> sequencer  marks in_byte as the final byte of the frame
//   out_ready  sequencer -> source  holding register empty; transfer on in_valid & out_ready
// Modports: master = byte source, slave = man_tx_ctrl.
interface man_tx_ctrl_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_last;
  logic       out_ready;

  modport master (
    output in_valid,
    output in_byte,
    output in_last,
    input  out_ready
  );

  modport slave (
    input  in_valid,
    input  in_byte,
    input  in_last,
    output out_ready
  );
endinterface

// File: rtl/man_tx_ctrl.sv
// man_tx_ctrl: frame sequencer in front of the Manchester encoder on the
// PICC->PCD transmit path (106 kb/s, clk = fc/16, ETU_CLKS clocks per ETU).
// A frame is SOF (one ETU of '1'), then per byte 8 data bits LSB first and an
// odd parity bit, then EOF_ETUS ETUs with the encoder disabled, then a done
// pulse. Consecutive bytes follow with no gap ETU when the next byte is
// already waiting; a missing byte at a byte boundary ends the frame with an
// underrun pulse.
//
// Optional feature: define MAN_TX_PARITY_EN to emit the parity bit after each
// byte. Without it the byte-boundary decision is taken at the end of bit 7.
//
// Ports:
//   clk             transmit clock, all logic on posedge
//   in_rst_n        synchronous active-low reset
//   bus             man_tx_ctrl_if.slave (in_valid/in_byte/in_last/out_ready)
//   out_mod_data    bit to the encoder data input (registered)
//   out_mod_enable  encoder enable, high during SOF/data/parity (registered)
//   out_busy        frame in progress, SOF through EOF
//   out_done        one-cycle pulse at the end of EOF
//   out_underrun    one-cycle pulse when no byte is available at a byte boundary
module man_tx_ctrl #(
  parameter int ETU_CLKS = 8,
  parameter int CNT_W    = 3,
  parameter int EOF_ETUS = 1
) (
  input  logic         clk,
  input  logic         in_rst_n,
  man_tx_ctrl_if.slave bus,
  output logic         out_mod_data,
  output logic         out_mod_enable,
  output logic         out_busy,
  output logic         out_done,
  output logic         out_underrun
);

  localparam int               EOF_W    = (EOF_ETUS > 1) ? $clog2(EOF_ETUS) : 1;
  localparam logic [CNT_W-1:0] ETU_LAST = CNT_W'(ETU_CLKS - 1);
  localparam logic [EOF_W-1:0] EOF_LAST = EOF_W'(EOF_ETUS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_PAR,
    ST_EOF
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] etu_cnt_q, etu_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [EOF_W-1:0] eof_cnt_q, eof_cnt_d;
  logic             full_q, full_d;
  logic [7:0]       hold_byte_q, hold_byte_d;
  logic             hold_last_q, hold_last_d;
  logic [7:0]       frame_byte_q, frame_byte_d;
  logic             frame_last_q, frame_last_d;
  logic             mod_data_q, mod_data_d;
  logic             mod_enable_q, mod_enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;

  logic             etu_end;
  logic             load;
  logic             unload;
  logic             boundary;

  assign etu_end       = (etu_cnt_q == ETU_LAST);
  assign load          = bus.in_valid & ~full_q;
  assign bus.out_ready = ~full_q;

  // Holding register: a load and an unload in the same cycle keep it full
  // with the newly offered byte.
  always_comb begin
    full_d      = load | (full_q & ~unload);
    hold_byte_d = load ? bus.in_byte : hold_byte_q;
    hold_last_d = load ? bus.in_last : hold_last_q;
  end

  always_comb begin
    state_d      = state_q;
    etu_cnt_d    = '0;
    bit_idx_d    = bit_idx_q;
    eof_cnt_d    = eof_cnt_q;
    frame_byte_d = frame_byte_q;
    frame_last_d = frame_last_q;
    mod_data_d   = mod_data_q;
    mod_enable_d = mod_enable_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    underrun_d   = 1'b0;
    unload       = 1'b0;
    boundary     = 1'b0;

    if (state_q != ST_IDLE) begin
      etu_cnt_d = etu_end ? '0 : etu_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // Leaving IDLE restarts the ETU counter at 0 so the encoder phase
        // lines up with the first SOF clock.
        if (full_q) begin
          state_d      = ST_SOF;
          unload       = 1'b1;
          frame_byte_d = hold_byte_q;
          frame_last_d = hold_last_q;
          mod_data_d   = 1'b1;
          mod_enable_d = 1'b1;
          busy_d       = 1'b1;
        end
      end
      ST_SOF: begin
        if (etu_end) begin
          state_d    = ST_DATA;
          bit_idx_d  = 3'd0;
          mod_data_d = frame_byte_q[0];
        end
      end
      ST_DATA: begin
        // Indexing the latched byte by bit_idx is equivalent to shifting it
        // right once per ETU and sending bit 0.
        if (etu_end) begin
          if (bit_idx_q != 3'd7) begin
            bit_idx_d  = bit_idx_q + 3'd1;
            mod_data_d = frame_byte_q[bit_idx_q + 3'd1];
          end else begin
`ifdef MAN_TX_PARITY_EN
            state_d    = ST_PAR;
            mod_data_d = ~^frame_byte_q;
`else
            boundary   = 1'b1;
`endif
          end
        end
      end
`ifdef MAN_TX_PARITY_EN
      ST_PAR: begin
        if (etu_end) begin
          boundary = 1'b1;
        end
      end
`endif
      ST_EOF: begin
        if (etu_end) begin
          if (eof_cnt_q == EOF_LAST) begin
            state_d   = ST_IDLE;
            eof_cnt_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            eof_cnt_d = eof_cnt_q + EOF_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Byte boundary: continue with the waiting byte, or close the frame.
    // Closing on a non-last byte is an underrun.
    if (boundary) begin
      if (!frame_last_q && full_q) begin
        state_d      = ST_DATA;
        bit_idx_d    = 3'd0;
        unload       = 1'b1;
        frame_byte_d = hold_byte_q;
        frame_last_d = hold_last_q;
        mod_data_d   = hold_byte_q[0];
      end else begin
        state_d      = ST_EOF;
        eof_cnt_d    = '0;
        mod_data_d   = 1'b0;
        mod_enable_d = 1'b0;
        underrun_d   = ~frame_last_q;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!in_rst_n) begin
      state_q      <= ST_IDLE;
      etu_cnt_q    <= '0;
      bit_idx_q    <= '0;
      eof_cnt_q    <= '0;
      full_q       <= 1'b0;
      mod_data_q   <= 1'b0;
      mod_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      etu_cnt_q    <= etu_cnt_d;
      bit_idx_q    <= bit_idx_d;
      eof_cnt_q    <= eof_cnt_d;
      full_q       <= full_d;
      mod_data_q   <= mod_data_d;
      mod_enable_q <= mod_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
    end
  end

  // Data registers, qualified by full_q / state, so they need no reset
  always_ff @(posedge clk) begin
    hold_byte_q  <= hold_byte_d;
    hold_last_q  <= hold_last_d;
    frame_byte_q <= frame_byte_d;
    frame_last_q <= frame_last_d;
  end

  assign out_mod_data   = mod_data_q;
  assign out_mod_enable = mod_enable_q;
  assign out_busy       = busy_q;
  assign out_done       = done_q;
  assign out_underrun   = underrun_q;

endmodule

// File: tb/tb_man_tx_ctrl.sv
// tb_man_tx_ctrl: directed and randomized frames for man_tx_ctrl. Expected
// bit streams come from a frame-level model (SOF, LSB-first bits, odd parity
// when MAN_TX_PARITY_EN is defined) and are compared ETU by ETU.
module tb_man_tx_ctrl;

  localparam int ETU_CLKS = 8;
  localparam int EOF_ETUS = 1;
`ifdef MAN_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic in_rst_n;
  logic out_mod_data, out_mod_enable, out_busy, out_done, out_underrun;

  man_tx_ctrl_if bus ();

  man_tx_ctrl #(.ETU_CLKS(ETU_CLKS), .CNT_W(3), .EOF_ETUS(EOF_ETUS)) dut (
    .clk            (clk),
    .in_rst_n       (in_rst_n),
    .bus            (bus),
    .out_mod_data   (out_mod_data),
    .out_mod_enable (out_mod_enable),
    .out_busy       (out_busy),
    .out_done       (out_done),
    .out_underrun   (out_underrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fb[$];
  bit         fl[$];
  bit         exp_bits[$];
  bit         exp_a[$];
  bit         exp_b[$];

  task automatic chk(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  function automatic bit odd_par(input logic [7:0] b);
    int ones = 0;
    for (int j = 0; j < 8; j++) ones += int'(b[j]);
    return (ones % 2) == 0;
  endfunction

  // Frame model: SOF '1', each byte LSB first, optional odd parity.
  function automatic void build_exp();
    exp_bits.delete();
    exp_bits.push_back(1'b1);
    foreach (fb[i]) begin
      for (int j = 0; j < 8; j++) exp_bits.push_back(fb[i][j]);
      if (PAR_EN) exp_bits.push_back(odd_par(fb[i]));
    end
  endfunction

  // Offer every byte of fb/fl in turn, holding valid until accepted.
  // Called at a negedge; returns at a negedge with valid low.
  task automatic feed();
    int n;
    for (int i = 0; i < fb.size(); i++) begin
      bus.in_valid = 1'b1;
      bus.in_byte  = fb[i];
      bus.in_last  = fl[i];
      n = 0;
      while (bus.out_ready !== 1'b1 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (n >= 400) chk("feed_timeout", i, 16'd0, 16'd1);
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // Follow one frame against exp_bits. Called at a negedge; samples the
  // current cycle first. Returns at the negedge showing the done pulse.
  task automatic check_frame(input bit exp_ur, output int wait_n);
    int  n;
    bit  ok;
    logic [4:0] obs, bad, exp5;
    n = 0;
    while (out_mod_enable !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    wait_n = n;
    if (n >= 300) begin
      chk("sof_timeout", 0, 16'd0, 16'd1);
      return;
    end
    for (int i = 0; i < exp_bits.size(); i++) begin
      ok   = 1'b1;
      bad  = '0;
      exp5 = {1'b1, exp_bits[i], 1'b1, 1'b0, 1'b0};
      for (int k = 0; k < ETU_CLKS; k++) begin
        if (i != 0 || k != 0) @(negedge clk);
        obs = {out_mod_enable, out_mod_data, out_busy, out_done, out_underrun};
        if (obs !== exp5 && ok) begin
          ok  = 1'b0;
          bad = obs;
        end
      end
      chk("etu_en_data_busy_done_ur", i, 16'(ok ? exp5 : bad), 16'(exp5));
    end
    for (int e = 0; e < EOF_ETUS * ETU_CLKS; e++) begin
      @(negedge clk);
      exp5 = {1'b0, 1'b0, 1'b1, 1'b0, (e == 0) ? exp_ur : 1'b0};
      obs  = {out_mod_enable, out_mod_data, out_busy, out_done, out_underrun};
      chk("eof_en_data_busy_done_ur", e, 16'(obs), 16'(exp5));
    end
    @(negedge clk);
    chk("done_busy_done_en", 0, 16'({out_busy, out_done, out_mod_enable}), 16'(3'b010));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int  n;
    int  wn;
    int  len;
    bit  seen;

    in_rst_n     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 0,
        16'({bus.out_ready, out_mod_data, out_mod_enable, out_busy, out_done, out_underrun}),
        16'(6'b100000));
    in_rst_n = 1'b1;
    @(negedge clk);

    // 1: single byte 0xA5, last; SOF two cycles after valid is first driven
    fb.delete(); fl.delete();
    fb.push_back(8'hA5); fl.push_back(1'b1);
    build_exp();
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hA5;
    bus.in_last  = 1'b1;
    @(negedge clk);
    chk("t1_ready_low_when_full", 0, 16'(bus.out_ready), 16'd0);
    bus.in_valid = 1'b0;
    check_frame(1'b0, wn);
    chk("t1_sof_latency", 0, 16'(wn), 16'd1);
    @(negedge clk);

    // 2: back-to-back 0x01 (not last), 0x00 (last), no gap ETU
    fb.delete(); fl.delete();
    fb.push_back(8'h01); fl.push_back(1'b0);
    fb.push_back(8'h00); fl.push_back(1'b1);
    build_exp();
    fork
      feed();
      check_frame(1'b0, wn);
      begin
        repeat (20) @(negedge clk);
        chk("t2_ready_low_second_byte_held", 0, 16'(bus.out_ready), 16'd0);
      end
    join
    @(negedge clk);

    // 3: 0x3C not last, then nothing -> underrun, EOF, done
    fb.delete(); fl.delete();
    fb.push_back(8'h3C); fl.push_back(1'b0);
    build_exp();
    fork
      feed();
      check_frame(1'b1, wn);
    join
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (out_mod_enable !== 1'b0 || out_busy !== 1'b0) seen = 1'b1;
    end
    chk("t3_quiet_after_underrun", 0, 16'(seen), 16'd0);

    // 4: reset during data bit 3 of 0x5A, then a clean 0xFF frame
    fb.delete(); fl.delete();
    fb.push_back(8'h5A); fl.push_back(1'b1);
    fork
      feed();
      begin
        n = 0;
        while (out_mod_enable !== 1'b1 && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("t4_sof_seen", 0, 16'(n < 100), 16'd1);
        repeat (ETU_CLKS * 4 + 3) @(negedge clk);
      end
    join
    chk("t4_bit3_before_reset", 0, 16'({out_mod_enable, out_mod_data}), 16'(2'b11));
    in_rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_reset_outputs", 0,
        16'({bus.out_ready, out_mod_data, out_mod_enable, out_busy, out_done, out_underrun}),
        16'(6'b100000));
    @(negedge clk);
    in_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (out_done !== 1'b0 || out_mod_enable !== 1'b0 || out_underrun !== 1'b0) seen = 1'b1;
    end
    chk("t4_no_done_after_abort", 0, 16'(seen), 16'd0);
    fb.delete(); fl.delete();
    fb.push_back(8'hFF); fl.push_back(1'b1);
    build_exp();
    fork
      feed();
      check_frame(1'b0, wn);
    join
    @(negedge clk);

    // 5: 0x80 last (parity presence follows the build)
    fb.delete(); fl.delete();
    fb.push_back(8'h80); fl.push_back(1'b1);
    build_exp();
    chk("t5_frame_etus", 0, 16'(exp_bits.size()), PAR_EN ? 16'd10 : 16'd9);
    fork
      feed();
      check_frame(1'b0, wn);
    join
    @(negedge clk);

    // 6: next frame's byte offered during EOF -> SOF right after done
    fb.delete(); fl.delete();
    fb.push_back(8'h99); fl.push_back(1'b1);
    build_exp();
    exp_b = exp_bits;
    fb.delete(); fl.delete();
    fb.push_back(8'h42); fl.push_back(1'b1);
    build_exp();
    exp_a = exp_bits;
    fork
      begin
        feed();
        n = 0;
        while (!(out_busy === 1'b1 && out_mod_enable === 1'b0) && n < 300) begin
          @(negedge clk);
          n++;
        end
        chk("t6_eof_reached", 0, 16'(n < 300), 16'd1);
        fb.delete(); fl.delete();
        fb.push_back(8'h99); fl.push_back(1'b1);
        feed();
      end
      begin
        exp_bits = exp_a;
        check_frame(1'b0, wn);
        @(negedge clk);
        exp_bits = exp_b;
        check_frame(1'b0, wn);
        chk("t6_sof_one_cycle_after_done", 0, 16'(wn), 16'd0);
      end
    join
    @(negedge clk);

    // Randomized multi-byte frames, bytes offered back to back
    for (int f = 0; f < 5; f++) begin
      fb.delete(); fl.delete();
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) begin
        fb.push_back(8'($urandom));
        fl.push_back(i == len - 1);
      end
      build_exp();
      fork
        feed();
        check_frame(1'b0, wn);
      join
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
